// File: rtl/quant_zigzag_pp.sv
// Quantiser + zigzag reorder for 8x8 DCT blocks.
// Two ping-pong banks; 3-stage read pipe (read, multiply, round/sat).
module quant_zigzag_pp #(
  parameter int DW = 12,
  parameter int OW = 12,
  parameter int RW = 17
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_comp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_last
);

  localparam int PW = DW + RW;
  localparam int QW = PW - 15;
  localparam logic [QW-1:0] QMAX = QW'((1 << (OW-1)) - 1);
  localparam logic [QW-1:0] QNEG = QW'(1 << (OW-1));
  localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

  localparam int unsigned ZZ [64] = '{
    0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
    12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
    35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
    58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

  localparam int unsigned QT [128] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,
    24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,
    72, 92, 95, 98,112,100,103, 99,
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99};

  // round(65536/Q), folded to constants at elaboration
  logic [RW-1:0] recip_rom [128];
  for (genvar g = 0; g < 128; g++) begin : g_rcp
    assign recip_rom[g] = RW'((32'd65536 + QT[g] / 2) / QT[g]);
  end

  logic signed [DW-1:0] mem [128];
  logic [1:0] full_q, full_d;
  logic [1:0] comp_q, comp_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;
  logic       wr_fire, rd_fire, en;
  logic [6:0] rd_addr, rcp_addr;

  logic                 s1_vld_q, s1_last_q;
  logic signed [DW-1:0] s1_x_q;
  logic [RW-1:0]        s1_r_q;
  logic                 s2_vld_q, s2_last_q, s2_neg_q;
  logic [PW-1:0]        s2_p_q;
  logic                 out_valid_q, out_last_q;
  logic signed [OW-1:0] out_data_q;

  logic [DW-1:0] mag;
  logic [PW-1:0] prod;
  logic [PW:0]   rnd;
  logic [QW-1:0] q;
  logic [OW-1:0] sat;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign en       = out_ready || !out_valid_q;
  assign rd_fire  = en && full_q[rd_bank_q];
  assign rd_addr  = {rd_bank_q, 6'(ZZ[rd_cnt_q])};
  assign rcp_addr = {comp_q[rd_bank_q], 6'(ZZ[rd_cnt_q])};

  always_comb begin
    full_d    = full_q;
    comp_d    = comp_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd0) comp_d[wr_bank_q] = in_comp;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    // write and read always touch opposite banks here
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_fire) mem[{wr_bank_q, wr_cnt_q}] <= in_data;
    if (en) begin
      s1_x_q <= mem[rd_addr];
      s1_r_q <= recip_rom[rcp_addr];
    end
  end

  assign mag  = s1_x_q[DW-1] ? DW'(-s1_x_q) : DW'(s1_x_q);
  assign prod = PW'(mag) * PW'(s1_r_q);
  assign rnd  = {1'b0, s2_p_q} + (PW+1)'(32'd32768);
  assign q    = QW'(rnd >> 16);

  always_comb begin
    sat = '0;
    if (s2_neg_q) sat = (q > QNEG) ? OMIN : OW'(0) - OW'(q);
    else          sat = (q > QMAX) ? OMAX : OW'(q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full_q      <= '0;
      comp_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_neg_q    <= 1'b0;
      s2_p_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      full_q    <= full_d;
      comp_q    <= comp_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      if (en) begin
        s1_vld_q    <= rd_fire;
        s1_last_q   <= (rd_cnt_q == 6'd63);
        s2_vld_q    <= s1_vld_q;
        s2_last_q   <= s1_last_q;
        s2_neg_q    <= s1_x_q[DW-1];
        s2_p_q      <= prod;
        out_valid_q <= s2_vld_q;
        out_last_q  <= s2_vld_q && s2_last_q;
        out_data_q  <= s2_vld_q ? sat : '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_quant_zigzag_pp.sv
// Directed bench for quant_zigzag_pp (DW=16).
// Output stream is captured into a queue and checked per block.
module tb_quant_zigzag_pp;

  localparam int DW = 16;
  localparam int OW = 12;
  localparam int RW = 17;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_comp = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [OW-1:0] out_data;
  logic                 out_last;

  always #5 sys_clk = ~sys_clk;

  quant_zigzag_pp #(.DW(DW), .OW(OW), .RW(RW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_comp  (in_comp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  int QL [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,
    24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,
    72, 92, 95, 98,112,100,103, 99};

  int ZZ [64] = '{
    0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
    12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
    35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
    58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

  typedef struct {
    int d;
    int l;
    int t;
  } ob_t;

  ob_t oq [$];
  int  blk [64];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  logic pv = 1'b0;
  logic pr = 1'b1;
  int   pd = 0;
  int   pl = 0;

  // capture handshakes; also hold-stability under backpressure
  always @(negedge sys_clk) begin
    if (sys_rst_n && pv && !pr) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), pd);
      check("hold_last", int'(out_last), pl);
    end
    pv = out_valid && sys_rst_n;
    pr = out_ready;
    pd = int'(out_data);
    pl = int'(out_last);
    if (sys_rst_n && out_valid && out_ready)
      oq.push_back('{int'(out_data), int'(out_last), cyc});
  end

  task automatic put(input int d, input logic c);
    int n = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_comp  = c;
    while (!in_ready && n < 3000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (n >= 3000) check("put_timeout", n, 0);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_blk(input logic c0, input logic crest);
    for (int r = 0; r < 64; r++)
      put(blk[r], (r == 0) ? c0 : crest);
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int k = 0; k < 5000 && oq.size() < n; k++) begin
      @(posedge sys_clk); #1;
    end
    check(tag, oq.size(), n);
  endtask

  task automatic check_zz_block(input string tag, input int base);
    ob_t o;
    for (int z = 0; z < 64; z++) begin
      if (oq.size() == 0) break;
      o = oq.pop_front();
      check(tag, o.d, base + ZZ[z]);
      check({tag, "_last"}, o.l, (z == 63) ? 1 : 0);
    end
  endtask

  task automatic fill_qr(input int base);
    for (int r = 0; r < 64; r++) blk[r] = QL[r] * (base + r);
  endtask

  initial begin
    ob_t o [64];
    int  n, lpos, lcnt, c0;
    int  bvals [3];

    // reset state
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // flat 160 luma block, latency and throughput
    for (int r = 0; r < 64; r++) blk[r] = 160;
    send_blk(1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("latency", n, 3);
    wait_out("flat_count", 64);
    lpos = -1;
    lcnt = 0;
    for (int i = 0; i < 64; i++) begin
      o[i] = oq.pop_front();
      if (o[i].l != 0) begin
        lpos = i;
        lcnt++;
      end
    end
    check("flat_z0", o[0].d, 10);
    check("flat_z1", o[1].d, 15);
    check("flat_z2", o[2].d, 13);
    check("flat_last_pos", lpos, 63);
    check("flat_last_cnt", lcnt, 1);
    check("flat_tput", o[63].t - o[0].t, 63);

    // x = Q*r reproduces the zigzag table
    fill_qr(0);
    send_blk(1'b0, 1'b0);
    wait_out("zz_count", 64);
    check_zz_block("zz", 0);

    // saturation and rounding at raster 0
    bvals = '{32767, -32768, -24};
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < 64; r++) blk[r] = 0;
      blk[0] = bvals[b];
      send_blk(1'b0, 1'b0);
      wait_out("sat_count", 64);
      o[0] = oq.pop_front();
      case (b)
        0: check("sat_pos", o[0].d, 2047);
        1: check("sat_neg", o[0].d, -2048);
        default: check("round_neg", o[0].d, -2);
      endcase
      oq.delete();
    end

    // chroma on sample 0, then luma with comp high on later samples
    for (int r = 0; r < 64; r++) blk[r] = 0;
    blk[0] = 170;
    blk[1] = 170;
    send_blk(1'b1, 1'b0);
    wait_out("chroma_count", 64);
    check("chroma_z0", oq[0].d, 10);
    check("chroma_z1", oq[1].d, 9);
    oq.delete();
    send_blk(1'b0, 1'b1);
    wait_out("luma_count", 64);
    check("luma_z0", oq[0].d, 11);
    check("luma_z1", oq[1].d, 15);
    oq.delete();

    // backpressure: two blocks fill with output blocked
    out_ready = 1'b0;
    c0 = cyc;
    for (int b = 0; b < 2; b++) begin
      fill_qr(64 * b);
      send_blk(1'b0, 1'b0);
    end
    check("bp_fill_cycles", cyc - c0, 128);
    check("bp_in_ready", int'(in_ready), 0);
    repeat (5) @(posedge sys_clk);
    #1;
    check("bp_still_blocked", int'(in_ready), 0);
    check("bp_no_output", oq.size(), 0);
    fork
      begin
        fill_qr(128);
        send_blk(1'b0, 1'b0);
      end
      begin
        for (int k = 0; k < 20000 && oq.size() < 192; k++) begin
          @(posedge sys_clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    check("bp_count", oq.size(), 192);
    check_zz_block("bp_b0", 0);
    check_zz_block("bp_b1", 64);
    check_zz_block("bp_b2", 128);

    // reset mid-block
    for (int r = 0; r < 40; r++) put(1000, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_out_last", int'(out_last), 0);
    check("post_rst_queue", oq.size(), 0);
    fill_qr(0);
    send_blk(1'b0, 1'b0);
    wait_out("rst_blk_count", 64);
    check_zz_block("rst_blk", 0);
    repeat (20) @(posedge sys_clk);
    #1;
    check("rst_no_extra", oq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
